// File: rtl/fp16_div_seq.sv
// fp16_div_seq: sequential IEEE-754 half-precision divider, q = a / b.
// This unit uses radix-2 restoring mantissa division and produces one quotient bit per clock.
// Results are rounded to nearest, ties to even.
// Subnormal inputs are flushed to zero, and the unit never produces a subnormal result.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake; a, b are captured on accept
//   a, b                 dividend / divisor (fp16)
//   out_valid/out_ready  result handshake; result is held until it is taken
//   result               quotient (fp16), registered
module fp16_div_seq #(
    parameter logic [15:0] NAN_VAL = 16'h7C01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result
);
    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

    state_t             r_state, w_next;
    logic [3:0]         r_cnt;
    logic               r_spec;
    logic               r_sign;
    logic [10:0]        r_mb;
    logic [11:0]        r_rem;
    logic [13:0]        r_q;
    logic signed [6:0]  r_e;
    logic [9:0]         r_mant;
    logic [15:0]        r_res;

    // ---------------- operand decode (combinational, used at accept) -----
    logic        w_accept, w_s;
    logic [4:0]  w_ea, w_eb;
    logic        w_az, w_bz, w_ainf, w_binf, w_anan, w_bnan;
    logic        w_is_nan, w_is_inf, w_is_zero, w_special;
    logic [15:0] w_spec_res;
    logic signed [6:0] w_e0;

    assign in_ready  = (r_state == IDLE) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == DONE);
    assign result    = r_res;

    assign w_s    = a[15] ^ b[15];
    assign w_ea   = a[14:10];
    assign w_eb   = b[14:10];
    // exponent field 0 covers both zero and subnormal (flushed)
    assign w_az   = (w_ea == 5'd0);
    assign w_bz   = (w_eb == 5'd0);
    assign w_ainf = (w_ea == 5'd31) && (a[9:0] == 10'd0);
    assign w_binf = (w_eb == 5'd31) && (b[9:0] == 10'd0);
    assign w_anan = (w_ea == 5'd31) && (a[9:0] != 10'd0);
    assign w_bnan = (w_eb == 5'd31) && (b[9:0] != 10'd0);

    assign w_is_nan  = w_anan || w_bnan || (w_az && w_bz) || (w_ainf && w_binf);
    assign w_is_inf  = (w_bz && !w_az) || (w_ainf && !w_binf);
    assign w_is_zero = w_az || w_binf;
    assign w_special = w_is_nan || w_is_inf || w_is_zero;

    always_comb begin
        w_spec_res = {w_s, 15'd0};
        if (w_is_nan)      w_spec_res = NAN_VAL;
        else if (w_is_inf) w_spec_res = {w_s, 5'h1F, 10'd0};
    end

    assign w_e0 = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 7'sd15;

    // ---------------- restoring division step ----------------------------
    // The remainder is kept pre-shifted, so the first quotient bit is the integer bit of ma/mb.
    logic        w_ge;
    logic [11:0] w_diff, w_rem_sel;
    assign w_ge      = (r_rem >= {1'b0, r_mb});
    assign w_diff    = r_rem - {1'b0, r_mb};
    assign w_rem_sel = w_ge ? w_diff : r_rem;

    // ---------------- normalise + round-to-nearest-even -------------------
    logic [13:0]       w_qn;
    logic signed [6:0] w_en, w_er;
    logic [10:0]       w_keep;
    logic              w_guard, w_sticky, w_inc, w_carry;
    logic [9:0]        w_mant_rnd;

    assign w_qn     = r_q[13] ? r_q : {r_q[12:0], 1'b0};
    assign w_en     = r_q[13] ? r_e : r_e - 7'sd1;
    assign w_keep   = w_qn[13:3];
    assign w_guard  = w_qn[2];
    assign w_sticky = (|w_qn[1:0]) || (r_rem != 12'd0);
    assign w_inc    = w_guard && (w_sticky || w_keep[0]);
    // A carry out of the 11-bit significand wraps the fraction to zero and increments the exponent.
    assign w_carry    = (&w_keep) && w_inc;
    assign w_mant_rnd = w_keep[9:0] + {9'd0, w_inc};
    assign w_er       = w_carry ? w_en + 7'sd1 : w_en;

    // ---------------- FSM ------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_accept) w_next = w_special ? ROUND : DIV;
            DIV:   if (r_cnt == 4'd13) w_next = ROUND;
            ROUND: if (r_cnt == 4'd1) w_next = DONE;
            DONE:  if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ---------------- datapath -------------------------------------------
    // ROUND spends two cycles.
    // At cnt=0 it normalises and rounds; at cnt=1 it range-checks and packs.
    // Special cases enter ROUND at cnt=1 with the result already loaded, so they finish one cycle after accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_spec <= 1'b0;
            r_sign <= 1'b0;
            r_mb   <= '0;
            r_rem  <= '0;
            r_q    <= '0;
            r_e    <= '0;
            r_mant <= '0;
            r_res  <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_sign <= w_s;
                    r_mb   <= {1'b1, b[9:0]};
                    r_rem  <= {2'b01, a[9:0]};
                    r_q    <= '0;
                    r_e    <= w_e0;
                    r_spec <= w_special;
                    if (w_special) begin
                        r_res <= w_spec_res;
                        r_cnt <= 4'd1;
                    end else begin
                        r_cnt <= 4'd0;
                    end
                end
                DIV: begin
                    r_q   <= {r_q[12:0], w_ge};
                    r_rem <= w_rem_sel << 1;
                    r_cnt <= (r_cnt == 4'd13) ? 4'd0 : r_cnt + 4'd1;
                end
                ROUND: begin
                    if (r_cnt == 4'd0) begin
                        r_mant <= w_mant_rnd;
                        r_e    <= w_er;
                        r_cnt  <= 4'd1;
                    end else if (!r_spec) begin
                        if (r_e >= 7'sd31)     r_res <= {r_sign, 5'h1F, 10'd0};
                        else if (r_e <= 7'sd0) r_res <= {r_sign, 15'd0};
                        else                   r_res <= {r_sign, r_e[4:0], r_mant};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp16_div_seq.sv
// Directed self-checking bench for fp16_div_seq.
module tb_fp16_div_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;

    fp16_div_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one operand pair and wait for the accept edge.
    task automatic launch(input logic [15:0] ta, input logic [15:0] tb_);
        @(negedge clk);
        chk("in_ready_before_launch", 32'(in_ready), 32'd1);
        a = ta; b = tb_; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'hFFFF; b = 16'hFFFF;  // operands need not be held
    endtask

    // Count edges after accept until out_valid rises (bounded).
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic take;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_after_take", 32'(out_valid), 32'd0);
        chk("in_ready_after_take", 32'(in_ready), 32'd1);
    endtask

    task automatic op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                      input logic [15:0] exp, input int lat);
        int n;
        launch(ta, tb_);
        wait_valid(n);
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_result"}, 32'(result), 32'(exp));
        take();
    endtask

    initial begin
        int n;
        logic [15:0] held;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        op("one_by_two",   16'h3C00, 16'h4000, 16'h3800, 16);
        op("three_by_two", 16'h4200, 16'h4000, 16'h3E00, 16);
        op("one_by_three", 16'h3C00, 16'h4200, 16'h3555, 16);
        op("neg_three_by_two", 16'hC200, 16'h4000, 16'hBE00, 16);
        op("neg_by_zero",  16'hBC00, 16'h0000, 16'hFC00, 1);
        op("zero_by_zero", 16'h0000, 16'h0000, 16'h7C01, 1);
        op("inf_by_inf",   16'h7C00, 16'h7C00, 16'h7C01, 1);
        op("one_by_inf",   16'h3C00, 16'h7C00, 16'h0000, 1);
        op("nan_operand",  16'h7E00, 16'h3C00, 16'h7C01, 1);
        op("inf_by_two",   16'h7C00, 16'h4000, 16'h7C00, 1);
        op("overflow",     16'h7BFF, 16'h0400, 16'h7C00, 16);
        op("underflow",    16'h0400, 16'h7BFF, 16'h0000, 16);
        op("subnormal_a",  16'h0200, 16'h3C00, 16'h0000, 1);

        // Backpressure: hold the result for 10 cycles while poking in_valid.
        launch(16'h3C00, 16'h4000);
        wait_valid(n);
        chk("hold_latency", 32'(n), 32'd16);
        held = result;
        chk("hold_initial", 32'(held), 32'h3800);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; a = 16'h4400; b = 16'h3C00;
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", 32'(result), 32'h3800);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        // in_valid high during the transfer cycle must not start an op
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("xfer_out_valid", 32'(out_valid), 32'd0);
        chk("xfer_no_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b0;

        // Reset in the middle of an op.
        launch(16'h4200, 16'h4000);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            chk("abort_no_result", 32'(out_valid), 32'd0);
        end
        op("after_abort", 16'h4400, 16'h3C00, 16'h4400, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
